si_window_countrate: RTL



---
 rtl/si_countrate_pkg.sv | 25 ++
 rtl/si_countrate_wb_regs.sv | 97 +++++++++
 rtl/si_window_countrate.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/si_countrate_pkg.sv
// Shared definitions for the windowed tag count-rate block: register map,
// control/status bit positions and the window state machine encoding.
package si_countrate_pkg;

  localparam logic [7:0] REG_CTRL        = 8'h00;
  localparam logic [7:0] REG_WLEN_LO     = 8'h04;
  localparam logic [7:0] REG_WLEN_HI     = 8'h08;
  localparam logic [7:0] REG_STATUS      = 8'h0C;
  localparam logic [7:0] REG_RESULT_BASE = 8'h80;

  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_FALLING_BIT = 1;

  localparam int STATUS_VALID_BIT = 0;
  localparam int STATUS_DISC_BIT  = 1;
  localparam int STATUS_SEQ_LSB   = 16;
  localparam int SEQ_WIDTH        = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/si_countrate_wb_regs.sv
// Wishbone slave for the count-rate block: CTRL/WLEN/STATUS registers,
// single-cycle ack generation and the registered read mux over the result bank.
module si_countrate_wb_regs
  import si_countrate_pkg::*;
#(
  parameter int NUM_CHANNELS = 32,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [7:0]                                wb_adr_i,
  input  logic [31:0]                               wb_dat_i,
  output logic [31:0]                               wb_dat_o,
  input  logic                                      wb_we_i,
  input  logic                                      wb_stb_i,
  input  logic                                      wb_cyc_i,
  output logic                                      wb_ack_o,
  input  logic [NUM_CHANNELS-1:0][COUNT_WIDTH-1:0]  result_i,
  input  logic [SEQ_WIDTH-1:0]                      seq_i,
  input  logic                                      snapshot_i,
  input  logic                                      disc_i,
  output logic                                      enable_o,
  output logic                                      count_falling_o,
  output logic [63:0]                               wlen_o,
  output logic                                      status_clr_o
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [63:0] wlen_q, wlen_d;
  logic        valid_q, valid_d;
  logic        access;
  logic        wr;
  logic [4:0]  rd_ch;
  logic [31:0] rd_data;

  always_comb begin
    access       = wb_cyc_i & wb_stb_i & ~ack_q;
    wr           = access & wb_we_i;
    rd_ch        = wb_adr_i[6:2];
    rd_data      = '0;
    ctrl_d       = ctrl_q;
    wlen_d       = wlen_q;
    status_clr_o = 1'b0;

    case (wb_adr_i)
      REG_CTRL:    rd_data = {30'd0, ctrl_q};
      REG_WLEN_LO: rd_data = wlen_q[31:0];
      REG_WLEN_HI: rd_data = wlen_q[63:32];
      REG_STATUS:  rd_data = {seq_i, 14'd0, disc_i, valid_q};
      default: begin
        // Result window: word-aligned only, channels beyond the bank read 0
        if (wb_adr_i[7] && (wb_adr_i[1:0] == 2'b00) && (int'(rd_ch) < NUM_CHANNELS))
          rd_data = 32'(result_i[rd_ch]);
      end
    endcase

    if (wr) begin
      case (wb_adr_i)
        REG_CTRL:    ctrl_d = {wb_dat_i[CTRL_FALLING_BIT], wb_dat_i[CTRL_ENABLE_BIT]};
        REG_WLEN_LO: wlen_d[31:0] = wb_dat_i;
        REG_WLEN_HI: wlen_d[63:32] = wb_dat_i;
        REG_STATUS:  status_clr_o = 1'b1;
        default:     ;
      endcase
    end

    // A snapshot landing on the same edge as a clear wins: the newer result stays flagged
    valid_d = snapshot_i ? 1'b1 : (status_clr_o ? 1'b0 : valid_q);
    ack_d   = access;
    dat_d   = access ? rd_data : dat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      ctrl_q  <= '0;
      wlen_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      ctrl_q  <= ctrl_d;
      wlen_q  <= wlen_d;
      valid_q <= valid_d;
    end
  end

  assign wb_ack_o        = ack_q;
  assign wb_dat_o        = dat_q;
  assign enable_o        = ctrl_q[CTRL_ENABLE_BIT];
  assign count_falling_o = ctrl_q[CTRL_FALLING_BIT];
  assign wlen_o          = wlen_q;

endmodule

// File: rtl/si_window_countrate.sv
// Per-channel tag counter over fixed windows of tag time; each window boundary
// snapshots the active counts into a result bank readable over Wishbone.
module si_window_countrate
  import si_countrate_pkg::*;
#(
  parameter int NUM_CHANNELS = 32,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tkeep,
  input  logic [4:0]  s_axis_channel,
  input  logic [63:0] s_axis_tagtime,
  input  logic        s_axis_rising_edge,
  input  logic [7:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  state_e                                   state_q, state_d;
  logic [63:0]                              window_end_q, window_end_d;
  logic [NUM_CHANNELS-1:0][COUNT_WIDTH-1:0] active_q, active_d;
  logic [NUM_CHANNELS-1:0][COUNT_WIDTH-1:0] result_q, result_d;
  logic [SEQ_WIDTH-1:0]                     seq_q, seq_d;
  logic                                     disc_q, disc_d;
  logic                                     snapshot;
  logic                                     enable;
  logic                                     count_falling;
  logic                                     status_clr;
  logic [63:0]                              wlen;
  logic                                     beat;
  logic                                     qualifies;
  logic [63:0]                              next_end;

  assign s_axis_tready = 1'b1;

  always_comb begin
    state_d      = state_q;
    window_end_d = window_end_q;
    active_d     = active_q;
    result_d     = result_q;
    seq_d        = seq_q;
    disc_d       = disc_q & ~status_clr;
    snapshot     = 1'b0;
    beat         = s_axis_tvalid & s_axis_tkeep & enable;
    qualifies    = beat & (int'(s_axis_channel) < NUM_CHANNELS)
                 & (s_axis_rising_edge | count_falling);
    next_end     = window_end_q + wlen;

    unique case (state_q)
      IDLE: begin
        active_d = '0;
        if (enable && (wlen != 64'd0)) state_d = ARM;
      end
      ARM: begin
        if (!enable || (wlen == 64'd0)) begin
          state_d = IDLE;
        end else if (beat) begin
          window_end_d = s_axis_tagtime + wlen;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (beat && (s_axis_tagtime >= window_end_q)) begin
          snapshot = 1'b1;
          result_d = active_q;
          seq_d    = seq_q + 1'b1;
          active_d = '0;
          // Within one window of the old boundary the grid is kept; a longer gap restarts it
          if (s_axis_tagtime < next_end) begin
            window_end_d = next_end;
          end else begin
            window_end_d = s_axis_tagtime + wlen;
            disc_d       = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (qualifies && (state_d == RUN)) begin
      if (active_d[s_axis_channel] != COUNT_MAX)
        active_d[s_axis_channel] = active_d[s_axis_channel] + 1'b1;
    end

    if (!enable) seq_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      window_end_q <= '0;
      active_q     <= '0;
      result_q     <= '0;
      seq_q        <= '0;
      disc_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      window_end_q <= window_end_d;
      active_q     <= active_d;
      result_q     <= result_d;
      seq_q        <= seq_d;
      disc_q       <= disc_d;
    end
  end

  si_countrate_wb_regs #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .COUNT_WIDTH  (COUNT_WIDTH)
  ) u_wb_regs (
    .clk             (clk),
    .rst_n           (rst_n),
    .wb_adr_i        (wb_adr_i),
    .wb_dat_i        (wb_dat_i),
    .wb_dat_o        (wb_dat_o),
    .wb_we_i         (wb_we_i),
    .wb_stb_i        (wb_stb_i),
    .wb_cyc_i        (wb_cyc_i),
    .wb_ack_o        (wb_ack_o),
    .result_i        (result_q),
    .seq_i           (seq_q),
    .snapshot_i      (snapshot),
    .disc_i          (disc_q),
    .enable_o        (enable),
    .count_falling_o (count_falling),
    .wlen_o          (wlen),
    .status_clr_o    (status_clr)
  );

endmodule
